// File: rtl/spdif_pkg.sv
// spdif_pkg: shared run classes, preamble types, FSM states and subframe slot indices
package spdif_pkg;
  typedef enum logic [1:0] {R1, R2, R3, ERR} run_class_t;
  typedef enum logic [1:0] {PRE_B, PRE_M, PRE_W} preamble_t;
  typedef enum logic [1:0] {HUNT, PRE, DATA} state_t;
  localparam int AUDIO_LSB = 4;
  localparam int V = 28;
  localparam int U = 29;
  localparam int C = 30;
  localparam int P = 31;
endpackage

// File: rtl/spdif_run_classifier.sv
// spdif_run_classifier: synchronizes the line, times runs between edges and classifies them
module spdif_run_classifier
  import spdif_pkg::*;
#(
  parameter int RUN1_MIN = 7,
  parameter int RUN2_MIN = 15,
  parameter int RUN3_MIN = 25,
  parameter int RUN3_MAX = 34
) (
  input  logic       clk_60mhz,
  input  logic       rst_n,
  input  logic       sdata_in,
  output logic       run_valid,
  output run_class_t run_class
);
  localparam int CW = $clog2(RUN3_MAX + 2);
  localparam logic [CW-1:0] T1 = CW'(RUN1_MIN);
  localparam logic [CW-1:0] T2 = CW'(RUN2_MIN);
  localparam logic [CW-1:0] T3 = CW'(RUN3_MIN);
  localparam logic [CW-1:0] TMAX = CW'(RUN3_MAX);
  localparam logic [CW-1:0] TSAT = CW'(RUN3_MAX + 1);
  localparam logic [CW-1:0] ONE = CW'(1);
  logic sync1, sync2, level, started, edge_det;
  logic [CW-1:0] cnt;
  run_class_t cls;
  assign edge_det = sync2 ^ level;
  assign cls = (cnt < T1 || cnt > TMAX) ? ERR : cnt >= T3 ? R3 : cnt >= T2 ? R2 : R1;
  // synchronize, detect edges and classify the run each edge closes; the first edge only arms timing
  always_ff @(posedge clk_60mhz or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      started <= 1'b0;
      cnt <= '0;
      run_valid <= 1'b0;
      run_class <= R1;
    end else begin
      sync1 <= sdata_in;
      sync2 <= sync1;
      level <= sync2;
      run_valid <= edge_det && started;
      cnt <= edge_det ? ONE : cnt == TSAT ? cnt : cnt + ONE;
      if (edge_det) begin
        started <= 1'b1;
        run_class <= cls;
      end
    end
  end
endmodule

// File: rtl/spdif_subframe_receiver.sv
// spdif_subframe_receiver: biphase-mark S/PDIF subframe decoder; SPDIF_PARITY_CHECK_EN enables parity checking
module spdif_subframe_receiver
  import spdif_pkg::*;
#(
  parameter int RUN1_MIN = 7,
  parameter int RUN2_MIN = 15,
  parameter int RUN3_MIN = 25,
  parameter int RUN3_MAX = 34
) (
  input  logic        clk_60mhz,
  input  logic        rst_n,
  input  logic        sdata_in,
  output logic [23:0] sample,
  output logic        chan_b,
  output logic        block_start,
  output logic        vbit,
  output logic        ubit,
  output logic        cbit,
  output logic        parity_err,
  output logic        sample_valid,
  output logic        locked
);
  logic run_valid, half, data_bit, last, perr_next, is_b, is_m, is_w;
  run_class_t rc, p1, p2;
  state_t state;
  preamble_t ptype;
  logic [1:0] pidx;
  logic [4:0] slot;
  logic [26:0] sh;
  logic [27:0] nxt;

  spdif_run_classifier #(
    .RUN1_MIN(RUN1_MIN),
    .RUN2_MIN(RUN2_MIN),
    .RUN3_MIN(RUN3_MIN),
    .RUN3_MAX(RUN3_MAX)
  ) u_cls (
    .clk_60mhz(clk_60mhz),
    .rst_n(rst_n),
    .sdata_in(sdata_in),
    .run_valid(run_valid),
    .run_class(rc)
  );

  assign data_bit = state == DATA && (rc == R2 ? !half : rc == R1 && half);
  assign nxt = {rc == R1, sh};
  assign last = slot == 5'(P);
  assign is_b = p2 == R1 && p1 == R1 && rc == R3;
  assign is_m = p2 == R3 && p1 == R1 && rc == R1;
  assign is_w = p2 == R2 && p1 == R1 && rc == R2;

`ifdef SPDIF_PARITY_CHECK_EN
  assign perr_next = ^nxt;
  // parity result is captured alongside the other fields at each strobe
  always_ff @(posedge clk_60mhz or negedge rst_n) begin
    if (!rst_n) parity_err <= 1'b0;
    else if (run_valid && data_bit && last) parity_err <= perr_next;
  end
`else
  assign perr_next = 1'b0;
  assign parity_err = 1'b0;
`endif

  // preamble hunt/match and bit decode; any bad run drops back to HUNT and clears locked
  always_ff @(posedge clk_60mhz or negedge rst_n) begin
    if (!rst_n) begin
      state <= HUNT;
      pidx <= 2'd0;
      p1 <= R1;
      p2 <= R1;
      ptype <= PRE_B;
      half <= 1'b0;
      slot <= 5'd0;
      sh <= '0;
      sample <= '0;
      chan_b <= 1'b0;
      block_start <= 1'b0;
      vbit <= 1'b0;
      ubit <= 1'b0;
      cbit <= 1'b0;
      sample_valid <= 1'b0;
      locked <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      if (run_valid) begin
        case (state)
          HUNT: if (rc == R3) begin
            state <= PRE;
            pidx <= 2'd1;
          end
          PRE: begin
            pidx <= pidx + 2'd1;
            p1 <= rc;
            p2 <= p1;
            if (rc == ERR || (pidx == 2'd0 && rc != R3) || (pidx == 2'd3 && !(is_b || is_m || is_w))) begin
              state <= HUNT;
              locked <= 1'b0;
            end else if (pidx == 2'd3) begin
              state <= DATA;
              slot <= 5'(AUDIO_LSB);
              half <= 1'b0;
              ptype <= is_b ? PRE_B : is_m ? PRE_M : PRE_W;
            end
          end
          DATA: if (data_bit) begin
            sh <= nxt[27:1];
            half <= 1'b0;
            slot <= slot + 5'd1;
            if (last) begin
              state <= PRE;
              pidx <= 2'd0;
              sample_valid <= 1'b1;
              sample <= nxt[23:0];
              vbit <= nxt[V-AUDIO_LSB];
              ubit <= nxt[U-AUDIO_LSB];
              cbit <= nxt[C-AUDIO_LSB];
              chan_b <= ptype == PRE_W;
              block_start <= ptype == PRE_B;
              locked <= !perr_next;
            end
          end else if (rc == R1) begin
            half <= 1'b1;
          end else begin
            state <= HUNT;
            locked <= 1'b0;
          end
          default: state <= HUNT;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_spdif_subframe_receiver.sv
// tb_spdif_subframe_receiver: random biphase-mark subframes with injected faults against a subframe-level model
module tb_spdif_subframe_receiver;
  logic clk_60mhz = 1'b0;
  logic rst_n = 1'b0;
  logic sdata_in = 1'b0;
  logic [23:0] sample;
  logic chan_b, block_start, vbit, ubit, cbit, parity_err, sample_valid, locked;
  int cyc = 0;
  int checks = 0;
  int passes = 0;

  typedef struct {int len; int sf; bit unl; bit rst;} run_t;
  typedef struct {logic [23:0] smp; int pre; bit v; bit u; bit c; bit perr; bit ok;} sf_t;
  typedef struct {int cyc; int sf;} ev_t;
  run_t runs[$];
  sf_t sfs[$];
  ev_t exp_q[$];
  bit pend_unl = 1'b0;
  logic [29:0] held = '0;

`ifdef SPDIF_PARITY_CHECK_EN
  localparam bit PCHK = 1'b1;
`else
  localparam bit PCHK = 1'b0;
`endif

  spdif_subframe_receiver dut (
    .clk_60mhz(clk_60mhz),
    .rst_n(rst_n),
    .sdata_in(sdata_in),
    .sample(sample),
    .chan_b(chan_b),
    .block_start(block_start),
    .vbit(vbit),
    .ubit(ubit),
    .cbit(cbit),
    .parity_err(parity_err),
    .sample_valid(sample_valid),
    .locked(locked)
  );

  always #8 clk_60mhz = ~clk_60mhz;
  always @(posedge clk_60mhz) cyc <= cyc + 1;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
  endtask

  function automatic int ui2clk(int ui, int mode);
    if (mode == 1) return ui == 1 ? 7 : ui == 2 ? 15 : 25;
    if (mode == 2) return ui == 1 ? 14 : ui == 2 ? 24 : 34;
    return ui == 1 ? int'($urandom_range(13, 8)) : ui == 2 ? int'($urandom_range(23, 16)) : int'($urandom_range(33, 26));
  endfunction

  // pre: 0=B 1=M 2=W; fault: 0 none, 1 parity flip, 2 replace first run of fslot by flen, 3 reset in fslot
  task automatic add_sf(int pre, logic [23:0] smp, int mode, int fault, int fslot, int flen);
    sf_t s;
    run_t r;
    int pu[4];
    logic [27:0] bits;
    s.smp = smp;
    s.pre = pre;
    s.v = 1'($urandom);
    s.u = 1'($urandom);
    s.c = 1'($urandom);
    s.perr = PCHK && fault == 1;
    s.ok = fault < 2;
    bits = {(^{s.c, s.u, s.v, smp}) ^ (fault == 1), s.c, s.u, s.v, smp};
    if (pre == 0) pu = '{3, 1, 1, 3};
    else if (pre == 1) pu = '{3, 3, 1, 1};
    else pu = '{3, 2, 1, 2};
    for (int j = 0; j < 4; j++) begin
      r.len = ui2clk(pu[j], mode);
      r.sf = -1;
      r.unl = pend_unl && j == 1;
      r.rst = 1'b0;
      runs.push_back(r);
    end
    pend_unl = fault >= 2;
    for (int k = 0; k < 28; k++) begin
      for (int j = 0; j < (bits[k] ? 2 : 1); j++) begin
        r.len = ui2clk(bits[k] ? 1 : 2, mode);
        r.sf = (k == 27 && j == (bits[k] ? 1 : 0)) ? sfs.size() : -1;
        r.unl = 1'b0;
        r.rst = 1'b0;
        if (k + 4 == fslot && j == 0) begin
          if (fault == 2) r.len = flen;
          if (fault == 3) r.rst = 1'b1;
        end
        runs.push_back(r);
      end
    end
    sfs.push_back(s);
  endtask

  task automatic cycle_check();
    ev_t e;
    sf_t s;
    bit hit;
    hit = exp_q.size() > 0 && exp_q[0].cyc == cyc;
    check("sample_valid", 32'(sample_valid), 32'(hit));
    if (hit) begin
      e = exp_q.pop_front();
      s = sfs[e.sf];
      held = {s.smp, s.pre == 2, s.pre == 0, s.v, s.u, s.c, s.perr};
      check("locked_at_strobe", 32'(locked), 32'(!s.perr));
    end
    check(hit ? "strobe_fields" : "held_fields",
          32'({sample, chan_b, block_start, vbit, ubit, cbit, parity_err}), 32'(held));
  endtask

  initial begin
    run_t r;
    ev_t e;
    bit lv;
    for (int i = 0; i < 3; i++) begin
      r.len = ui2clk(2, 0);
      r.sf = -1;
      r.unl = 1'b0;
      r.rst = 1'b0;
      runs.push_back(r);
    end
    add_sf(0, 24'h123456, 0, 0, 0, 0);
    add_sf(2, 24'hABCDEF, 0, 0, 0, 0);
    add_sf(1, 24'h123456, 0, 0, 0, 0);
    add_sf(2, 24'hABCDEF, 0, 0, 0, 0);
    add_sf(1, 24'($urandom), 1, 0, 0, 0);
    add_sf(2, 24'($urandom), 2, 0, 0, 0);
    add_sf(1, 24'($urandom), 0, 1, 0, 0);
    add_sf(2, 24'($urandom), 0, 0, 0, 0);
    add_sf(1, 24'($urandom), 0, 2, 12, 80);
    add_sf(2, 24'($urandom), 0, 0, 0, 0);
    add_sf(1, 24'($urandom), 0, 2, 15, 6);
    add_sf(2, 24'($urandom), 0, 0, 0, 0);
    add_sf(1, 24'($urandom), 0, 2, 16, 35);
    add_sf(2, 24'($urandom), 0, 0, 0, 0);
    add_sf(1, 24'($urandom), 0, 3, 20, 0);
    add_sf(2, 24'($urandom), 0, 0, 0, 0);
    for (int k = 0; k < 8; k++) begin
      add_sf(k == 4 ? 0 : 1, 24'($urandom), 0, 0, 0, 0);
      add_sf(2, 24'($urandom), 0, 0, 0, 0);
    end
    repeat (2) @(posedge clk_60mhz);
    #1;
    check("reset_outputs", {sample, chan_b, block_start, vbit, ubit, cbit, parity_err, sample_valid, locked}, 32'd0);
    #2 rst_n = 1'b1;
    @(posedge clk_60mhz);
    #1;
    lv = 1'b0;
    for (int i = 0; i < runs.size(); i++) begin
      lv = ~lv;
      sdata_in = lv;
      if (i > 0 && runs[i-1].sf >= 0 && sfs[runs[i-1].sf].ok) begin
        e.cyc = cyc + 4;
        e.sf = runs[i-1].sf;
        exp_q.push_back(e);
      end
      if (runs[i].unl) check("unlocked_after_abort", 32'(locked), 32'd0);
      for (int c = 0; c < runs[i].len; c++) begin
        @(posedge clk_60mhz);
        #1;
        cycle_check();
        if (runs[i].rst && c == 1) begin
          #2 rst_n = 1'b0;
          #1 check("async_reset", {sample, chan_b, block_start, vbit, ubit, cbit, parity_err, sample_valid, locked}, 32'd0);
          held = '0;
        end
        if (runs[i].rst && c == 3) #2 rst_n = 1'b1;
      end
    end
    sdata_in = ~lv;
    if (runs[runs.size()-1].sf >= 0) begin
      e.cyc = cyc + 4;
      e.sf = runs[runs.size()-1].sf;
      exp_q.push_back(e);
    end
    repeat (20) begin
      @(posedge clk_60mhz);
      #1;
      cycle_check();
    end
    check("pending_strobes", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/spdif_subframe_receiver.md
SPDIF_SUBFRAME_RECEIVER -- requirements
Module: spdif_subframe_receiver

Interface
REQ-001 SHALL have parameter RUN1_MIN, default 7, meaning the minimum clk_60mhz count classified as a 1-UI run.
REQ-002 SHALL have parameter RUN2_MIN, default 15, meaning the minimum count classified as a 2-UI run.
REQ-003 SHALL have parameter RUN3_MIN, default 25, meaning the minimum count classified as a 3-UI run.
REQ-004 SHALL have parameter RUN3_MAX, default 34, meaning the maximum legal run; longer runs are errors.
REQ-005 SHALL have port clk_60mhz, input, 1 bit: the single clock; all logic uses its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port sdata_in, input, 1 bit: asynchronous biphase-mark S/PDIF line from the optical receiver.
REQ-008 SHALL have port sample, output, 24 bits: audio word (time slots 4-27), MSB = slot 27.
REQ-009 SHALL have port chan_b, output, 1 bit: 1 = subframe began with preamble W, 0 = B or M.
REQ-010 SHALL have port block_start, output, 1 bit: subframe began with preamble B.
REQ-011 SHALL have port vbit/ubit/cbit, output, 1 bit each: slots 28/29/30.
REQ-012 SHALL have port parity_err, output, 1 bit: even parity over slots 4-31 failed.
REQ-013 SHALL have port sample_valid, output, 1 bit: one-cycle strobe qualifying sample through parity_err.
REQ-014 SHALL have port locked, output, 1 bit: high while decoding without run errors.

Function
REQ-015 SHALL pass sdata_in through a 2-flop synchronizer, then a flop that registers the synchronized level for edge detection.
REQ-016 SHALL count clocks between consecutive edges, saturating at RUN3_MAX+1, and classify each run as R1, R2 or R3, or as ERR when count < RUN1_MIN or > RUN3_MAX.
REQ-017 SHALL run the FSM states HUNT, PRE, and DATA.
REQ-018 HUNT: on an R3 run, go to PRE; all other runs are ignored.
REQ-019 PRE: match the 3 runs after the leading R3: B = R1,R1,R3; M = R3,R1,R1; W = R2,R1,R2. On a match, latch the preamble type, clear the slot counter to 4, and go to DATA; on a mismatch or ERR, go to HUNT.
REQ-020 DATA: an R2 decodes as bit 0; two consecutive R1 runs decode as bit 1. A single R1 followed by R2/R3, any R3, or ERR SHALL go to HUNT and clear locked.
REQ-021 DATA: shift decoded bits LSB-first into slots 4-31; after slot 31, go to PRE without passing through HUNT. The leading R3 of the next preamble is the run that follows.
REQ-022 SHALL assert sample_valid for exactly one clock, 4 clk_60mhz cycles after the sdata_in transition that closes slot 31, with all outputs updated in that same cycle.
REQ-023 sample, chan_b, block_start, vbit, ubit, cbit and parity_err SHALL hold their values between strobes.
REQ-024 locked SHALL rise at the first sample_valid after HUNT and fall in the cycle an error sends the FSM to HUNT.
REQ-025 A subframe aborted mid-DATA SHALL produce no sample_valid and SHALL leave the held outputs unchanged.
REQ-026 An edge at the exact threshold count SHALL take the higher class (count == RUN2_MIN is R2).

Reset
REQ-027 While rst_n = 0: all outputs 0, FSM in HUNT, counters and synchronizer 0; assertion SHALL take effect immediately, mid-subframe included.
REQ-028 After release, the first edge SHALL only start a run measurement; no run is classified until a second edge occurs.

Configuration
REQ-029 With SPDIF_PARITY_CHECK_EN defined, parity_err SHALL be computed, and a subframe with parity_err = 1 SHALL still strobe sample_valid but SHALL clear locked.
REQ-030 Without SPDIF_PARITY_CHECK_EN, parity_err SHALL be tied to 0 and no parity logic synthesized.

Structure
REQ-031 Package spdif_pkg SHALL hold the run_class_t enum (R1, R2, R3, ERR), the preamble_t enum (PRE_B, PRE_M, PRE_W), the fsm state enum, and the slot-index constants (AUDIO_LSB = 4, V = 28, U = 29, C = 30, P = 31).
REQ-032 Run measurement and classification (REQ-015/016) SHALL be sub-module spdif_run_classifier; the target RTL size is 150-300 lines in total.

Verification
REQ-033 Stimulus: stereo frames at 6.144 MHz UI, B/A sample 24'h123456, W/B sample 24'hABCDEF. Required response: strobes alternate, chan_b = 0 then 1, block_start = 1 on the first only, sample values exact, locked = 1 after the first strobe.
REQ-034 Stimulus: the parity bit of one subframe is flipped, with the macro defined. Required response: parity_err = 1 and locked = 0 at that strobe; without the macro, parity_err = 0.
REQ-035 Stimulus: an 80-clock idle gap injected in slot 12. Required response: no strobe for that subframe, locked = 0, and the next valid preamble relocks.
REQ-036 Stimulus: rst_n pulsed low during slot 20. Required response: outputs = 0 immediately, and the first strobe after reset belongs to the next complete subframe.
REQ-037 Stimulus: runs of exactly 7, 15, 25 and 34 clocks and of 6 and 35 clocks. Required response: the first four decode legally; 6 and 35 force HUNT.
